// File: rtl/decode_wb_fwd_regs.sv
// decode_wb_fwd_regs
// ------------------
// Decode / write-back block of the pipelined Y86-64 core.
//   * Owns the architectural register file; write-back happens at the
//     rising edge from the W stage (W_dstE/W_valE and W_dstM/W_valM).
//   * Derives srcA/srcB/dstE/dstM from the decode-stage instruction.
//   * Resolves valA/valB through the e/M/W forwarding network.
//   * Owns the D->E pipeline register with stall/bubble control.
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   D_*                           decode-stage instruction fields (from D register)
//   e_dstE, e_valE                execute-stage forwarding source
//   M_dstE, M_dstM, M_valE, m_valM memory-stage forwarding sources
//   W_dstE, W_dstM, W_valE, W_valM write-back ports, also forwarding sources
//   E_stall, E_bubble             E register control (bubble dominates stall)
//   d_srcA, d_srcB, d_dstE, d_dstM combinational IDs for the hazard unit
//   E_*                           registered execute-stage fields
//
// Handshake: there is no valid/ready protocol here; the hazard unit steers the
// E register with E_stall/E_bubble, and every cycle without either loads the
// decode-stage instruction.

module decode_wb_fwd_regs #(
    parameter int                 DATA_W      = 64,
    parameter int                 NUM_REGS    = 15,
    parameter int                 RNONE       = 15,
    parameter int                 RSP_ID      = 4,
    parameter logic [DATA_W-1:0]  RSP_INIT    = '0,
    parameter int                 STAT_W      = 4,
    parameter logic [STAT_W-1:0]  BUBBLE_STAT = STAT_W'(8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        D_icode,
    input  logic [3:0]        D_ifun,
    input  logic [3:0]        D_rA,
    input  logic [3:0]        D_rB,
    input  logic [STAT_W-1:0] D_Stat,
    input  logic [DATA_W-1:0] D_valC,
    input  logic [DATA_W-1:0] D_valP,
    input  logic [3:0]        e_dstE,
    input  logic [DATA_W-1:0] e_valE,
    input  logic [3:0]        M_dstE,
    input  logic [3:0]        M_dstM,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [3:0]        W_dstE,
    input  logic [3:0]        W_dstM,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [DATA_W-1:0] W_valM,
    input  logic              E_stall,
    input  logic              E_bubble,
    output logic [3:0]        d_srcA,
    output logic [3:0]        d_srcB,
    output logic [3:0]        d_dstE,
    output logic [3:0]        d_dstM,
    output logic [3:0]        E_icode,
    output logic [3:0]        E_ifun,
    output logic [STAT_W-1:0] E_Stat,
    output logic [DATA_W-1:0] E_valC,
    output logic [DATA_W-1:0] E_valA,
    output logic [DATA_W-1:0] E_valB,
    output logic [3:0]        E_dstE,
    output logic [3:0]        E_dstM,
    output logic [3:0]        E_srcA,
    output logic [3:0]        E_srcB
);

    localparam logic [3:0] RNONE_ID  = 4'(RNONE);
    localparam logic [3:0] REG_LIMIT = 4'(NUM_REGS);
    localparam logic [3:0] RSP       = 4'(RSP_ID);

    localparam logic [3:0] I_NOP    = 4'd1;
    localparam logic [3:0] I_RRMOVQ = 4'd2;
    localparam logic [3:0] I_IRMOVQ = 4'd3;
    localparam logic [3:0] I_RMMOVQ = 4'd4;
    localparam logic [3:0] I_MRMOVQ = 4'd5;
    localparam logic [3:0] I_OPQ    = 4'd6;
    localparam logic [3:0] I_JXX    = 4'd7;
    localparam logic [3:0] I_CALL   = 4'd8;
    localparam logic [3:0] I_RET    = 4'd9;
    localparam logic [3:0] I_PUSHQ  = 4'd10;
    localparam logic [3:0] I_POPQ   = 4'd11;

    typedef struct packed {
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [STAT_W-1:0] stat;
        logic [DATA_W-1:0] valc;
        logic [DATA_W-1:0] vala;
        logic [DATA_W-1:0] valb;
        logic [3:0]        dste;
        logic [3:0]        dstm;
        logic [3:0]        srca;
        logic [3:0]        srcb;
    } e_reg_t;

    localparam e_reg_t E_BUBBLE = '{
        icode: I_NOP,
        ifun:  4'd0,
        stat:  BUBBLE_STAT,
        valc:  '0,
        vala:  '0,
        valb:  '0,
        dste:  RNONE_ID,
        dstm:  RNONE_ID,
        srca:  RNONE_ID,
        srcb:  RNONE_ID
    };

    // ------------------------------------------------------------------
    // Register file with write-back
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // The dstM write is applied last so it wins when both target one register.
    // RNONE is >= NUM_REGS, so the range test also drops "no register".
    always_comb begin
        regs_d = regs_q;
        if (W_dstE < REG_LIMIT) begin
            regs_d[W_dstE] = W_valE;
        end
        if (W_dstM < REG_LIMIT) begin
            regs_d[W_dstM] = W_valM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == RSP_ID) ? RSP_INIT : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // ------------------------------------------------------------------
    // Source / destination ID generation
    // ------------------------------------------------------------------
    always_comb begin
        d_srcA = RNONE_ID;
        d_srcB = RNONE_ID;
        d_dstE = RNONE_ID;
        d_dstM = RNONE_ID;

        case (D_icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: d_srcA = D_rA;
            I_RET, I_POPQ:                      d_srcA = RSP;
            default:                            d_srcA = RNONE_ID;
        endcase

        case (D_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:          d_srcB = D_rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     d_srcB = RSP;
            default:                            d_srcB = RNONE_ID;
        endcase

        case (D_icode)
            I_RRMOVQ, I_IRMOVQ, I_OPQ:          d_dstE = D_rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     d_dstE = RSP;
            default:                            d_dstE = RNONE_ID;
        endcase

        case (D_icode)
            I_MRMOVQ, I_POPQ:                   d_dstM = D_rA;
            default:                            d_dstM = RNONE_ID;
        endcase
    end

    // ------------------------------------------------------------------
    // Register read and forwarding
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] d_valA;
    logic [DATA_W-1:0] d_valB;

    // Out-of-range IDs (including RNONE) read as zero.
    always_comb begin
        rf_a = '0;
        rf_b = '0;
        if (d_srcA < REG_LIMIT) begin
            rf_a = regs_q[d_srcA];
        end
        if (d_srcB < REG_LIMIT) begin
            rf_b = regs_q[d_srcB];
        end
    end

    // Youngest producer wins. The W-stage entries also cover a read of a
    // register written at this same edge, so the file needs no bypass.
    always_comb begin
        d_valA = rf_a;
        if (D_icode == I_JXX || D_icode == I_CALL) begin
            d_valA = D_valP;
        end else if (d_srcA != RNONE_ID) begin
            if      (d_srcA == e_dstE) d_valA = e_valE;
            else if (d_srcA == M_dstM) d_valA = m_valM;
            else if (d_srcA == M_dstE) d_valA = M_valE;
            else if (d_srcA == W_dstM) d_valA = W_valM;
            else if (d_srcA == W_dstE) d_valA = W_valE;
            else                       d_valA = rf_a;
        end
    end

    always_comb begin
        d_valB = rf_b;
        if (d_srcB != RNONE_ID) begin
            if      (d_srcB == e_dstE) d_valB = e_valE;
            else if (d_srcB == M_dstM) d_valB = m_valM;
            else if (d_srcB == M_dstE) d_valB = M_valE;
            else if (d_srcB == W_dstM) d_valB = W_valM;
            else if (d_srcB == W_dstE) d_valB = W_valE;
            else                       d_valB = rf_b;
        end
    end

    // ------------------------------------------------------------------
    // D->E pipeline register
    // ------------------------------------------------------------------
    e_reg_t e_q;
    e_reg_t e_d;

    always_comb begin
        e_d = e_q;
        if (E_bubble) begin
            e_d = E_BUBBLE;
        end else if (!E_stall) begin
            e_d.icode = D_icode;
            e_d.ifun  = D_ifun;
            e_d.stat  = D_Stat;
            e_d.valc  = D_valC;
            e_d.vala  = d_valA;
            e_d.valb  = d_valB;
            e_d.dste  = d_dstE;
            e_d.dstm  = d_dstM;
            e_d.srca  = d_srcA;
            e_d.srcb  = d_srcB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_q <= E_BUBBLE;
        end else begin
            e_q <= e_d;
        end
    end

    assign E_icode = e_q.icode;
    assign E_ifun  = e_q.ifun;
    assign E_Stat  = e_q.stat;
    assign E_valC  = e_q.valc;
    assign E_valA  = e_q.vala;
    assign E_valB  = e_q.valb;
    assign E_dstE  = e_q.dste;
    assign E_dstM  = e_q.dstm;
    assign E_srcA  = e_q.srca;
    assign E_srcB  = e_q.srcb;

endmodule

// File: tb/tb_decode_wb_fwd_regs.sv
// Testbench for decode_wb_fwd_regs: directed vectors, a behavioural model of
// the register file / E register checked every cycle at the falling edge, and
// literal expectations checked one time unit after selected rising edges.

module tb_decode_wb_fwd_regs;

    localparam logic [63:0] RSP_INIT_V = 64'h0000_0000_0000_1000;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  D_icode, D_ifun, D_rA, D_rB, D_Stat;
    logic [63:0] D_valC, D_valP;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic        E_stall, E_bubble;
    logic [3:0]  d_srcA, d_srcB, d_dstE, d_dstM;
    logic [3:0]  E_icode, E_ifun, E_Stat;
    logic [63:0] E_valC, E_valA, E_valB;
    logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;

    decode_wb_fwd_regs #(
        .DATA_W(64), .NUM_REGS(15), .RNONE(15), .RSP_ID(4),
        .RSP_INIT(RSP_INIT_V), .STAT_W(4), .BUBBLE_STAT(4'd8)
    ) dut (
        .clk(clk), .rst(rst),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_Stat(D_Stat), .D_valC(D_valC), .D_valP(D_valP),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
        .E_stall(E_stall), .E_bubble(E_bubble),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
        .E_icode(E_icode), .E_ifun(E_ifun), .E_Stat(E_Stat),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
    );

    // ------------------------------------------------------------------
    // Scoreboard bookkeeping
    // ------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: register array plus expected E fields
    // ------------------------------------------------------------------
    logic [63:0] m_regs [0:14];
    logic [3:0]  m_icode, m_ifun, m_stat, m_dste, m_dstm, m_srca, m_srcb;
    logic [63:0] m_valc, m_vala, m_valb;
    bit          m_valid = 1'b0;

    function automatic logic [3:0] f_srca(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'd2, 4'd4, 4'd6, 4'd10}) return ra;
        if (ic inside {4'd9, 4'd11})             return 4'd4;
        return 4'd15;
    endfunction

    function automatic logic [3:0] f_srcb(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'd4, 4'd5, 4'd6})        return rb;
        if (ic inside {4'd8, 4'd9, 4'd10, 4'd11}) return 4'd4;
        return 4'd15;
    endfunction

    function automatic logic [3:0] f_dste(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'd2, 4'd3, 4'd6})        return rb;
        if (ic inside {4'd8, 4'd9, 4'd10, 4'd11}) return 4'd4;
        return 4'd15;
    endfunction

    function automatic logic [3:0] f_dstm(input logic [3:0] ic, input logic [3:0] ra);
        return (ic inside {4'd5, 4'd11}) ? ra : 4'd15;
    endfunction

    function automatic logic [63:0] f_read(input logic [3:0] id);
        return (id < 4'd15) ? m_regs[id] : 64'd0;
    endfunction

    // Youngest in-flight producer first, register file last.
    function automatic logic [63:0] f_value(input logic [3:0] src);
        if (src == 4'd15)  return 64'd0;
        if (src == e_dstE) return e_valE;
        if (src == M_dstM) return m_valM;
        if (src == M_dstE) return M_valE;
        if (src == W_dstM) return W_valM;
        if (src == W_dstE) return W_valE;
        return f_read(src);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) m_regs[i] <= (i == 4) ? RSP_INIT_V : 64'd0;
            m_icode <= 4'd1; m_ifun <= 4'd0; m_stat <= 4'd8;
            m_valc <= 64'd0; m_vala <= 64'd0; m_valb <= 64'd0;
            m_dste <= 4'd15; m_dstm <= 4'd15; m_srca <= 4'd15; m_srcb <= 4'd15;
            m_valid <= 1'b1;
        end else begin
            // dstM is scheduled second, so it wins a same-register conflict.
            if (W_dstE < 4'd15) m_regs[W_dstE] <= W_valE;
            if (W_dstM < 4'd15) m_regs[W_dstM] <= W_valM;
            if (E_bubble) begin
                m_icode <= 4'd1; m_ifun <= 4'd0; m_stat <= 4'd8;
                m_valc <= 64'd0; m_vala <= 64'd0; m_valb <= 64'd0;
                m_dste <= 4'd15; m_dstm <= 4'd15; m_srca <= 4'd15; m_srcb <= 4'd15;
            end else if (!E_stall) begin
                m_icode <= D_icode; m_ifun <= D_ifun; m_stat <= D_Stat; m_valc <= D_valC;
                m_vala  <= (D_icode inside {4'd7, 4'd8}) ? D_valP : f_value(f_srca(D_icode, D_rA));
                m_valb  <= f_value(f_srcb(D_icode, D_rB));
                m_dste  <= f_dste(D_icode, D_rB);
                m_dstm  <= f_dstm(D_icode, D_rA);
                m_srca  <= f_srca(D_icode, D_rA);
                m_srcb  <= f_srcb(D_icode, D_rB);
            end
        end
    end

    // Compare process: every falling edge once the model is initialised.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_E_icode", {60'd0, E_icode}, {60'd0, m_icode});
            chk("cyc_E_ifun",  {60'd0, E_ifun},  {60'd0, m_ifun});
            chk("cyc_E_Stat",  {60'd0, E_Stat},  {60'd0, m_stat});
            chk("cyc_E_valC",  E_valC, m_valc);
            chk("cyc_E_valA",  E_valA, m_vala);
            chk("cyc_E_valB",  E_valB, m_valb);
            chk("cyc_E_ids",   {48'd0, E_dstE, E_dstM, E_srcA, E_srcB},
                               {48'd0, m_dste, m_dstm, m_srca, m_srcb});
            chk("cyc_d_ids",   {48'd0, d_srcA, d_srcB, d_dstE, d_dstM},
                               {48'd0, f_srca(D_icode, D_rA), f_srcb(D_icode, D_rB),
                                f_dste(D_icode, D_rB), f_dstm(D_icode, D_rA)});
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (inputs change one time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] valc, input logic [63:0] valp);
        D_icode = ic; D_ifun = 4'd0; D_rA = ra; D_rB = rb;
        D_valC = valc; D_valP = valp; D_Stat = 4'd1;
    endtask

    task automatic clear_fwd();
        e_dstE = 4'd15; M_dstE = 4'd15; M_dstM = 4'd15; W_dstE = 4'd15; W_dstM = 4'd15;
        e_valE = 64'd0; M_valE = 64'd0; m_valM = 64'd0; W_valE = 64'd0; W_valM = 64'd0;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    initial begin
        set_d(4'd1, 4'd15, 4'd15, 64'd0, 64'd0);
        clear_fwd();
        E_stall = 1'b0; E_bubble = 1'b0;
        rst = 1'b1;

        // Reset
        tick(); tick();
        chk("rst_E_icode", {60'd0, E_icode}, 64'd1);
        chk("rst_E_Stat",  {60'd0, E_Stat},  64'd8);
        chk("rst_E_ids",   {48'd0, E_dstE, E_dstM, E_srcA, E_srcB}, 64'hFFFF);
        rst = 1'b0;

        // Read every register through rrmovq
        for (int r = 0; r < 15; r++) begin
            set_d(4'd2, 4'(r), 4'd15, 64'd0, 64'd0);
            tick();
            chk($sformatf("rst_reg%0d", r), E_valA, (r == 4) ? RSP_INIT_V : 64'd0);
        end

        // irmovq write-back, then opq with no forwarding
        set_d(4'd3, 4'd15, 4'd3, 64'd2, 64'd0);
        W_dstE = 4'd3; W_valE = 64'd2;
        tick();
        clear_fwd();
        set_d(4'd6, 4'd3, 4'd3, 64'd0, 64'd0);
        tick();
        chk("opq_valA", E_valA, 64'd2);
        chk("opq_valB", E_valB, 64'd2);
        chk("opq_dstE", {60'd0, E_dstE}, 64'd3);

        // Forwarding priority
        set_d(4'd2, 4'd11, 4'd15, 64'd0, 64'd0);
        e_dstE = 4'd11; e_valE = 64'd5;
        M_dstE = 4'd11; M_valE = 64'd6;
        W_dstE = 4'd11; W_valE = 64'd7;
        tick();
        chk("fwd_e", E_valA, 64'd5);
        e_dstE = 4'd15;
        tick();
        chk("fwd_M", E_valA, 64'd6);
        M_dstE = 4'd15;
        tick();
        chk("fwd_W", E_valA, 64'd7);
        clear_fwd();
        set_d(4'd2, 4'd12, 4'd15, 64'd0, 64'd0);
        M_dstM = 4'd12; m_valM = 64'h55; M_dstE = 4'd12; M_valE = 64'h66;
        tick();
        chk("fwd_mM_over_ME", E_valA, 64'h55);
        clear_fwd();
        W_dstM = 4'd12; W_valM = 64'h77; W_dstE = 4'd12; W_valE = 64'h88;
        tick();
        chk("fwd_WM_over_WE", E_valA, 64'h77);
        clear_fwd();
        tick();
        chk("wb_conflict_reg12", E_valA, 64'h77);

        // popq with write-back conflict on rsp
        set_d(4'd1, 4'd15, 4'd15, 64'd0, 64'd0);
        W_dstE = 4'd4; W_dstM = 4'd4; W_valE = 64'd2047; W_valM = 64'd23;
        tick();
        clear_fwd();
        set_d(4'd11, 4'd5, 4'd15, 64'd0, 64'd0);
        #1;
        chk("popq_d_srcA", {60'd0, d_srcA}, 64'd4);
        chk("popq_d_srcB", {60'd0, d_srcB}, 64'd4);
        chk("popq_d_dstM", {60'd0, d_dstM}, 64'd5);
        tick();
        chk("popq_rsp", E_valA, 64'd23);
        chk("popq_valB", E_valB, 64'd23);

        // call and jXX
        set_d(4'd8, 4'd15, 4'd15, 64'h100, 64'd23);
        W_dstE = 4'd4; W_valE = 64'd2039;
        tick();
        chk("call_valA", E_valA, 64'd23);
        chk("call_valB", E_valB, 64'd2039);
        chk("call_dstE", {60'd0, E_dstE}, 64'd4);
        clear_fwd();
        set_d(4'd7, 4'd15, 4'd15, 64'h200, 64'h40);
        tick();
        chk("jxx_valA", E_valA, 64'h40);
        chk("jxx_valB", E_valB, 64'd0);
        chk("jxx_valC", E_valC, 64'h200);

        // Stall and bubble
        set_d(4'd6, 4'd1, 4'd2, 64'd0, 64'd0);
        tick();
        chk("pre_stall_icode", {60'd0, E_icode}, 64'd6);
        E_stall = 1'b1;
        set_d(4'd3, 4'd15, 4'd9, 64'd9, 64'd0);
        W_dstE = 4'd9; W_valE = 64'h99;
        tick();
        clear_fwd();
        tick();
        chk("stall_icode", {60'd0, E_icode}, 64'd6);
        chk("stall_dstE",  {60'd0, E_dstE},  64'd2);
        E_bubble = 1'b1;
        tick();
        chk("bubble_icode", {60'd0, E_icode}, 64'd1);
        chk("bubble_Stat",  {60'd0, E_Stat},  64'd8);
        E_bubble = 1'b0; E_stall = 1'b0;
        set_d(4'd2, 4'd9, 4'd15, 64'd0, 64'd0);
        tick();
        chk("wb_during_stall", E_valA, 64'h99);

        // Reset while stalled discards the pending write
        E_stall = 1'b1; rst = 1'b1;
        W_dstE = 4'd7; W_valE = 64'd99;
        tick();
        chk("rst_stall_icode", {60'd0, E_icode}, 64'd1);
        chk("rst_stall_dstE",  {60'd0, E_dstE},  64'd15);
        rst = 1'b0; E_stall = 1'b0;
        clear_fwd();
        set_d(4'd2, 4'd7, 4'd15, 64'd0, 64'd0);
        tick();
        chk("rst_drop_wb", E_valA, 64'd0);
        set_d(4'd2, 4'd9, 4'd15, 64'd0, 64'd0);
        tick();
        chk("rst_clear_reg9", E_valA, 64'd0);
        set_d(4'd2, 4'd4, 4'd15, 64'd0, 64'd0);
        tick();
        chk("rst_rsp_init", E_valA, RSP_INIT_V);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
